ibex_fetch_fifo_credit: RTL and testbench
=========================================

// Module: ibex_fetch_fifo_credit
// PURPOSE
//  Next-generation instruction fetch FIFO between the prefetch buffer and the ID/IF stage.
//  Buffers word-aligned 32-bit fetch responses and realigns them into (possibly compressed,
//  halfword-aligned) instructions. Storage depth is decoupled from the request count, and
//  in-flight requests are tracked by credit, so in_ready_o no longer reserves NUM_REQS slots.
//  Responses to requests issued before a clear are counted and silently discarded.
// PARAMETERS
//  DEPTH     4  storage entries (32b data + err); legal range 2..16
//  NUM_REQS  2  max outstanding memory requests; legal range 1..DEPTH
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  rst_i            in   1   synchronous, active-high reset
//  clear_i          in   1   flush: drop contents, reload address from in_addr_i
//  in_addr_i        in   32  new instruction address; sampled only when clear_i=1 ([0] unused)
//  req_issue_i      in   1   a fetch request was accepted by memory this cycle
//  in_ready_o       out  1   prefetcher may issue one more request this cycle
//  in_valid_i       in   1   fetch response valid (one per issued request, in order)
//  in_rdata_i       in   32  response word
//  in_err_i         in   1   response bus error
//  out_valid_o      out  1   complete instruction available
//  out_ready_i      in   1   consumer accepts instruction
//  out_addr_o       out  32  instruction address, bit 0 always 0
//  out_rdata_o      out  32  instruction bits (upper 16 don't-care if compressed)
//  out_err_o        out  1   fetch error on any word the instruction uses
//  out_err_plus2_o  out  1   error lies only in second half of an unaligned 32b instruction
//  occupancy_o      out  $clog2(DEPTH+1)   stored entries (excludes bypass word)
//  outstanding_o    out  $clog2(NUM_REQS+1) in-flight requests incl. ones being discarded
// BEHAVIOUR
//  - Reset: entries invalid, occupancy_o=0, outstanding_o=0, discard count=0, out_addr_o=0,
//    out_valid_o=0, in_ready_o=1. Reset has priority over clear_i and all other inputs.
//  - Storage: circular buffer, rd_ptr/wr_ptr mod DEPTH, count_q. Logical queue = stored entries
//    (oldest first) followed by the accepted in_valid_i word (bypass, zero latency).
//  - Accept: in_valid_i & ~clear_i & (discard_q==0) -> word pushed at wr_ptr.
//  - Pop: fire = out_valid_o & out_ready_i. Pop one logical entry when the instruction
//    ends in, or consumes the top half of, the head word (i.e. not aligned-compressed).
//    Push and pop in one cycle leave count_q unchanged and advance both pointers, including
//    count_q=0 where the bypassed word is pushed and immediately popped.
//  - Aligner: addr[1]=0: head word; compressed iff [1:0]!=2'b11. addr[1]=1: head[31:16];
//    compressed iff head[17:16]!=2'b11, else needs next logical word, data={next[15:0],head[31:16]}.
//    out_valid_o = all needed words present in the logical queue.
//  - Errors: out_err_o = OR of err of words used; out_err_plus2_o = unaligned uncompressed &
//    ~err(head) & err(next); 0 in the aligned case.
//  - Address: on clear_i load in_addr_i[31:1]; on fire add 2 (compressed) or 4; wraps mod 2^32.
//  - Credits: outstanding_d = outstanding_q + req_issue_i - in_valid_i.
//    in_ready_o = (outstanding_q < NUM_REQS) & (count_q + outstanding_q - discard_q < DEPTH).
//    req_issue_i while in_ready_o=0 or in_valid_i with outstanding_q=0 is illegal (asserted).
//  - Clear: next cycle count_q=0, pointers 0, discard_d = outstanding_q - in_valid_i
//    (in_valid_i in clear cycle is dropped; req_issue_i in clear cycle belongs to the new stream
//    and is not discarded). While discard_q>0, each in_valid_i decrements discard_q and is dropped,
//    out_valid_o stays 0. A second clear_i reloads discard from current outstanding.
//  - Full: count_q==DEPTH never receives an accepted word (guaranteed by credit); asserted.
// TESTING
//  1 Reset, then req_issue x2, responses 0x00000013,0x00000013 at addr 0x100 -> two aligned 32b
//    instrs at 0x100,0x104 with out_valid_o on response cycle (bypass), occupancy_o stays 0.
//  2 Word 0x0001_4501 at addr 0x200 -> c.li at 0x200 (no pop), then 0x0001 at 0x202, occupancy 1->0.
//  3 clear_i to 0x302, words 0x0013_xxxx,0x0000_0000 -> out_rdata_o=0x0000_0013, valid only when
//    second word arrives; err on 2nd word only -> out_err_o=1, out_err_plus2_o=1.
//  4 NUM_REQS=2: two requests in flight, clear_i -> next two in_valid_i dropped, out_valid_o=0,
//    outstanding_o 2->1->0, then new-stream response delivered at in_addr_i.
//  5 DEPTH=4, out_ready_i=0, keep issuing -> in_ready_o drops when occupancy+outstanding=4,
//    never overflows; release out_ready_i -> pointers wrap past entry 3 with data in order.
//  6 rst_i asserted mid-stream with full FIFO and clear_i=1 -> all reset values next cycle.

Source files
------------

// File: rtl/ibex_fetch_fifo_credit.sv
// Instruction fetch FIFO with credit-based request tracking and a halfword realigner.
// Stored entries plus a zero-latency bypass of the incoming response form the logical queue.
module ibex_fetch_fifo_credit #(
    parameter int DEPTH    = 4,
    parameter int NUM_REQS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [31:0]                   in_addr_i,
    input  logic                          req_issue_i,
    output logic                          in_ready_o,
    input  logic                          in_valid_i,
    input  logic [31:0]                   in_rdata_i,
    input  logic                          in_err_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_addr_o,
    output logic [31:0]                   out_rdata_o,
    output logic                          out_err_o,
    output logic                          out_err_plus2_o,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
    output logic [$clog2(NUM_REQS+1)-1:0] outstanding_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(NUM_REQS + 1);
    localparam int SW = CW + 2;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [OW-1:0] REQ_MAX  = OW'(NUM_REQS);

    logic [31:0]   r_mem_data [DEPTH];
    logic          r_mem_err  [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;
    logic [31:1]   r_addr;

    logic          w_push;
    logic          w_pop;
    logic          w_fire;
    logic          w_comp;
    logic          w_have_head;
    logic          w_have_next;
    logic [PW-1:0] w_rd_nxt;
    logic [31:0]   w_head_data;
    logic [31:0]   w_next_data;
    logic          w_head_err;
    logic          w_next_err;
    logic [SW-1:0] w_credit;
    logic          w_unused_addr0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_unused_addr0 = in_addr_i[0];

    // Responses still owed to a flushed stream are dropped instead of entering the queue.
    assign w_push   = in_valid_i & ~clear_i & (r_discard == '0);
    assign w_rd_nxt = ptr_inc(r_rd_ptr);

    assign w_head_data = (r_count != '0) ? r_mem_data[r_rd_ptr] : in_rdata_i;
    assign w_head_err  = (r_count != '0) ? r_mem_err[r_rd_ptr]  : in_err_i;
    assign w_next_data = (r_count > CW'(1)) ? r_mem_data[w_rd_nxt] : in_rdata_i;
    assign w_next_err  = (r_count > CW'(1)) ? r_mem_err[w_rd_nxt]  : in_err_i;
    assign w_have_head = (r_count != '0) | w_push;
    assign w_have_next = (r_count > CW'(1)) | ((r_count == CW'(1)) & w_push);

    always_comb begin
        w_comp          = 1'b0;
        out_valid_o     = 1'b0;
        out_rdata_o     = w_head_data;
        out_err_o       = w_head_err;
        out_err_plus2_o = 1'b0;
        if (!r_addr[1]) begin
            w_comp      = (w_head_data[1:0] != 2'b11);
            out_valid_o = w_have_head;
        end else begin
            w_comp      = (w_head_data[17:16] != 2'b11);
            out_rdata_o = {w_next_data[15:0], w_head_data[31:16]};
            if (w_comp) begin
                out_valid_o = w_have_head;
            end else begin
                out_valid_o     = w_have_head & w_have_next;
                out_err_o       = w_head_err | w_next_err;
                out_err_plus2_o = ~w_head_err & w_next_err;
            end
        end
    end

    // An aligned compressed instruction leaves the top half of the head word for the next one.
    assign w_fire = out_valid_o & out_ready_i;
    assign w_pop  = w_fire & (r_addr[1] | ~w_comp);

    assign w_credit   = SW'(r_count) + SW'(r_outstanding) - SW'(r_discard);
    assign in_ready_o = (r_outstanding < REQ_MAX) & (w_credit < SW'(DEPTH));

    assign out_addr_o    = {r_addr, 1'b0};
    assign occupancy_o   = r_count;
    assign outstanding_o = r_outstanding;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_rdata_i;
            r_mem_err[r_wr_ptr]  <= in_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_addr        <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(req_issue_i) - OW'(in_valid_i);
            if (clear_i) begin
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_discard <= r_outstanding - OW'(in_valid_i);
                r_addr    <= in_addr_i[31:1];
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_nxt;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if ((r_discard != '0) && in_valid_i) begin
                    r_discard <= r_discard - OW'(1);
                end
                if (w_fire) begin
                    r_addr <= r_addr + (w_comp ? 31'd1 : 31'd2);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(req_issue_i && !in_ready_o));
            assert (!(in_valid_i && (r_outstanding == '0)));
            assert (!(w_push && (r_count == CNT_FULL)));
        end
    end

endmodule

// File: tb/tb_ibex_fetch_fifo_credit.sv
// Directed vector table plus multi-cycle sequences for the credit fetch FIFO.
module tb_ibex_fetch_fifo_credit;

    logic        clk = 1'b0;
    logic        rst, clr, iss, vld, err, ordy;
    logic [31:0] addr, rdata;
    logic        irdy, ovld, oerr, op2;
    logic [31:0] oaddr, odata;
    logic [2:0]  occ;
    logic [1:0]  outs;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ibex_fetch_fifo_credit #(.DEPTH(4), .NUM_REQS(2)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .in_addr_i(addr),
        .req_issue_i(iss), .in_ready_o(irdy), .in_valid_i(vld),
        .in_rdata_i(rdata), .in_err_i(err), .out_valid_o(ovld),
        .out_ready_i(ordy), .out_addr_o(oaddr), .out_rdata_o(odata),
        .out_err_o(oerr), .out_err_plus2_o(op2), .occupancy_o(occ),
        .outstanding_o(outs)
    );

    typedef struct {
        logic        rst, clr;
        logic [31:0] addr;
        logic        iss, vld;
        logic [31:0] rdata;
        logic        err, ordy;
        logic        chk;
        logic        ovld;
        logic [31:0] oaddr, odata, omask;
        logic        oerr, op2, irdy;
        int          occ, outs;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, c, input logic [31:0] a, input logic i, vl,
                     input logic [31:0] d, input logic e, o, input logic ck, ov,
                     input logic [31:0] oa, od, om, input logic oe, p2, ir,
                     input int oc, ou);
        vec_t t;
        t.rst = r; t.clr = c; t.addr = a; t.iss = i; t.vld = vl; t.rdata = d;
        t.err = e; t.ordy = o; t.chk = ck; t.ovld = ov; t.oaddr = oa; t.odata = od;
        t.omask = om; t.oerr = oe; t.op2 = p2; t.irdy = ir; t.occ = oc; t.outs = ou;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Model state for the multi-cycle sequences
    int          m_count, m_outs, m_issued, m_delivered, m_seq;
    logic [31:0] m_addr;
    logic [31:0] m_q[$];

    task automatic drive(input logic r, c, input logic [31:0] a, input logic i, vl,
                         input logic [31:0] d, input logic e, o);
        rst = r; clr = c; addr = a; iss = i; vld = vl; rdata = d; err = e; ordy = o;
    endtask

    task automatic step(input logic want_iss, input logic o);
        logic        m_irdy, s_iss, s_vld, exp_ovld, fire;
        logic [31:0] d;
        m_irdy   = (m_outs < 2) && (m_count + m_outs < 4);
        s_iss    = want_iss && m_irdy;
        s_vld    = (m_outs != 0);
        d        = 32'h0000_0013 | (32'(m_seq) << 20);
        if (s_vld) m_q.push_back(d);
        exp_ovld = (m_count + (s_vld ? 1 : 0)) > 0;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, s_iss, s_vld, d, 1'b0, o);
        #2;
        chk("seq_irdy", 32'(irdy), 32'(m_irdy));
        chk("seq_occ", 32'(occ), 32'(m_count));
        chk("seq_outs", 32'(outs), 32'(m_outs));
        chk("seq_ovld", 32'(ovld), 32'(exp_ovld));
        if (exp_ovld) begin
            chk("seq_data", odata, m_q[0]);
            chk("seq_addr", oaddr, m_addr);
        end
        fire = exp_ovld && o;
        @(posedge clk);
        if (fire) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
            m_delivered++;
        end
        m_count = m_count + (s_vld ? 1 : 0) - (fire ? 1 : 0);
        m_outs  = m_outs + (s_iss ? 1 : 0) - (s_vld ? 1 : 0);
        if (s_iss) m_issued++;
        if (s_vld) m_seq++;
    endtask

    localparam logic [31:0] FM = 32'hFFFF_FFFF;
    localparam logic [31:0] HM = 32'h0000_FFFF;

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        //   rst clr addr         iss vld rdata         err ordy chk ovld oaddr         odata         mask oerr p2 irdy occ outs
        v(1, 0, 32'h0,        0, 0, 32'h0,          0, 0,  0, 0, 32'h0,        32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 0,  1, 0, 32'h0,        32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 1, 32'h100,      0, 0, 32'h0,          0, 0,  1, 0, 32'h0,        32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h100,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h100,      32'h0,        0,  0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 1, 32'h13,         0, 1,  1, 1, 32'h100,      32'h13,       FM, 0, 0, 0, 0, 2);
        v(0, 0, 32'h0,        0, 1, 32'h13,         0, 1,  1, 1, 32'h104,      32'h13,       FM, 0, 0, 1, 0, 1);
        v(0, 1, 32'h200,      0, 0, 32'h0,          0, 0,  1, 0, 32'h108,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h200,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        0, 1, 32'h0001_4501,  0, 1,  1, 1, 32'h200,      32'h4501,     HM, 0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 1,  1, 1, 32'h202,      32'h0001,     HM, 0, 0, 1, 1, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 0,  1, 0, 32'h204,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 1, 32'h302,      0, 0, 32'h0,          0, 0,  1, 0, 32'h204,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h302,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h0013_ABCD,  0, 1,  1, 0, 32'h302,      32'h0,        0,  0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 1, 32'h0,          1, 0,  1, 1, 32'h302,      32'h13,       FM, 1, 1, 1, 1, 1);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 1,  1, 1, 32'h302,      32'h13,       FM, 1, 1, 1, 2, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 1,  1, 1, 32'h306,      32'h0,        HM, 1, 0, 1, 1, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 0,  1, 0, 32'h308,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h308,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h308,      32'h0,        0,  0, 0, 1, 0, 1);
        v(0, 1, 32'h400,      0, 0, 32'h0,          0, 0,  1, 0, 32'h308,      32'h0,        0,  0, 0, 0, 0, 2);
        v(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,  0, 1,  1, 0, 32'h400,      32'h0,        0,  0, 0, 0, 0, 2);
        v(0, 0, 32'h0,        0, 1, 32'h1111_1111,  0, 1,  1, 0, 32'h400,      32'h0,        0,  0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 1,  1, 0, 32'h400,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        0, 1, 32'h00A0_0093,  0, 1,  1, 1, 32'h400,      32'h00A0_0093, FM, 0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 0,  1, 0, 32'h404,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'h404,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 1, 32'h500,      1, 0, 32'h0,          0, 0,  1, 0, 32'h404,      32'h0,        0,  0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 1, 32'h0BAD_0BAD,  0, 1,  1, 0, 32'h500,      32'h0,        0,  0, 0, 0, 0, 2);
        v(0, 0, 32'h0,        0, 1, 32'h13,         0, 1,  1, 1, 32'h500,      32'h13,       FM, 0, 0, 1, 0, 1);
        v(0, 1, 32'hFFFF_FFFD, 0, 0, 32'h0,         0, 0,  1, 0, 32'h504,      32'h0,        0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,          0, 0,  1, 0, 32'hFFFF_FFFC, 32'h0,       0,  0, 0, 1, 0, 0);
        v(0, 0, 32'h0,        0, 1, 32'h13,         0, 1,  1, 1, 32'hFFFF_FFFC, 32'h13,      FM, 0, 0, 1, 0, 1);
        v(0, 0, 32'h0,        0, 0, 32'h0,          0, 0,  1, 0, 32'h0,        32'h0,        0,  0, 0, 1, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].clr, vq[i].addr, vq[i].iss, vq[i].vld,
                  vq[i].rdata, vq[i].err, vq[i].ordy);
            #2;
            if (vq[i].chk) begin
                chk($sformatf("v%0d_ovld", i), 32'(ovld), 32'(vq[i].ovld));
                chk($sformatf("v%0d_irdy", i), 32'(irdy), 32'(vq[i].irdy));
                chk($sformatf("v%0d_occ", i), 32'(occ), 32'(vq[i].occ));
                chk($sformatf("v%0d_outs", i), 32'(outs), 32'(vq[i].outs));
                chk($sformatf("v%0d_addr", i), oaddr, vq[i].oaddr);
                if (vq[i].ovld) begin
                    chk($sformatf("v%0d_data", i), odata & vq[i].omask, vq[i].odata);
                    chk($sformatf("v%0d_err", i), 32'(oerr), 32'(vq[i].oerr));
                    chk($sformatf("v%0d_plus2", i), 32'(op2), 32'(vq[i].op2));
                end
            end
        end

        // Back-pressure: fill to the credit limit, then drain through the pointer wrap
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        m_addr = 32'h600; m_count = 0; m_outs = 0; m_issued = 0; m_delivered = 0; m_seq = 1;
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        chk("full_occ_model", 32'(m_count), 32'd4);
        for (int c = 0; c < 40 && m_delivered < 10; c++) step(m_issued < 10, 1'b1);
        chk("drain_delivered", 32'(m_delivered), 32'd10);

        // Reset while full with clear asserted
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        chk("pre_rst_occ", 32'(occ), 32'd4);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_ovld", 32'(ovld), 32'd0);
        chk("rst_addr", oaddr, 32'h0);
        chk("rst_irdy", 32'(irdy), 32'd1);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_outs", 32'(outs), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
